// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, FSM encoding and op-context bus for the iterative multiply/divide unit.
// Helper predicates decode the op code so the datapath never compares raw encodings.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_CALC  = 3'd1,
        MD_FIXUP = 3'd2,
        MD_DONE  = 3'd3,
        MD_DZERO = 3'd4
    } md_state_t;

    typedef enum logic {
        MD_MODE_MUL = 1'b0,
        MD_MODE_DIV = 1'b1
    } md_mode_t;

    // Everything about the accepted op that the fix-up stage still needs.
    typedef struct packed {
        md_op_t op;
        logic   neg_res;
        logic   neg_rem;
    } md_op_bus_t;

    function automatic logic op_is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic logic op_is_acc(md_op_t op);
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

    function automatic logic op_is_sub(md_op_t op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> multiply/divide unit request/response bundle.
// slave is the unit side, master is the EX/ctrl side.
interface ex_muldiv_if #(parameter int DATA_W = 32);
    import ex_muldiv_pkg::*;

    logic                  start_i;
    md_op_t                op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [DATA_W-1:0]     acc_hi_i;
    logic [DATA_W-1:0]     acc_lo_i;
    logic                  annul_i;
    logic                  stall_i;
    logic                  stallreq_o;
    logic                  ready_o;
    logic [2*DATA_W-1:0]   result_o;

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, acc_hi_i, acc_lo_i, annul_i, stall_i,
        output stallreq_o, ready_o, result_o
    );

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, acc_hi_i, acc_lo_i, annul_i, stall_i,
        input  stallreq_o, ready_o, result_o
    );

endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration, combinational: shift-add multiply or restoring divide step.
// {hi,lo} is the partial product, or {partial remainder, dividend/quotient} for divide.
module muldiv_step
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  md_mode_t          mode,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] hi_nxt,
    output logic [DATA_W-1:0] lo_nxt
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[DATA_W-1]};
        // Remainder stays below the divisor, so the top bit of the trial is its sign.
        trial   = shifted - {1'b0, operand};
        hi_nxt  = hi;
        lo_nxt  = lo;
        if (mode == MD_MODE_MUL) begin
            {hi_nxt, lo_nxt} = {sum, lo[DATA_W-1:1]};
        end else if (!trial[DATA_W]) begin
            hi_nxt = trial[DATA_W-1:0];
            lo_nxt = {lo[DATA_W-2:0], 1'b1};
        end else begin
            hi_nxt = shifted[DATA_W-1:0];
            lo_nxt = {lo[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/DIV/MADD/MSUB unit: DATA_W+2 cycles from acceptance to ready (2 on divide-by-zero).
// Holds the result in DONE while stall_i is high; start_i low or annul_i aborts back to IDLE.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   md
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    md_state_t             state;
    md_op_bus_t            ctx;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     hi_q;
    logic [DATA_W-1:0]     lo_q;
    logic [DATA_W-1:0]     opnd_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic                  ready_q;
    logic [2*DATA_W-1:0]   result_q;

    logic                  sgn1;
    logic                  sgn2;
    logic [DATA_W-1:0]     mag1;
    logic [DATA_W-1:0]     mag2;
    md_mode_t              step_mode;
    logic [DATA_W-1:0]     step_hi;
    logic [DATA_W-1:0]     step_lo;
    logic [2*DATA_W-1:0]   prod_raw;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;
    logic [2*DATA_W-1:0]   fixed;

    always_comb begin
        sgn1 = op_is_signed(md.op_i) & md.opdata1_i[DATA_W-1];
        sgn2 = op_is_signed(md.op_i) & md.opdata2_i[DATA_W-1];
        mag1 = sgn1 ? -md.opdata1_i : md.opdata1_i;
        mag2 = sgn2 ? -md.opdata2_i : md.opdata2_i;
    end

    assign step_mode = op_is_div(ctx.op) ? MD_MODE_DIV : MD_MODE_MUL;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .mode    (step_mode),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_nxt  (step_hi),
        .lo_nxt  (step_lo)
    );

    // Sign restoration and accumulate; all 2*DATA_W arithmetic wraps.
    always_comb begin
        prod_raw = {hi_q, lo_q};
        prod_fix = ctx.neg_res ? -prod_raw : prod_raw;
        quo      = ctx.neg_res ? -lo_q : lo_q;
        rem      = ctx.neg_rem ? -hi_q : hi_q;
        fixed    = prod_fix;
        if (op_is_div(ctx.op)) begin
            fixed = {rem, quo};
        end else if (op_is_acc(ctx.op)) begin
            fixed = op_is_sub(ctx.op) ? (acc_q - prod_fix) : (acc_q + prod_fix);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MD_IDLE;
            ctx      <= '0;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (md.annul_i) begin
            state   <= MD_IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md.start_i) begin
                        ctx.op      <= md.op_i;
                        ctx.neg_res <= sgn1 ^ sgn2;
                        ctx.neg_rem <= sgn1;
                        cnt         <= '0;
                        hi_q        <= '0;
                        acc_q       <= {md.acc_hi_i, md.acc_lo_i};
                        // Divide shifts the dividend out of lo; multiply shifts the multiplier.
                        if (op_is_div(md.op_i)) begin
                            lo_q   <= mag1;
                            opnd_q <= mag2;
                        end else begin
                            lo_q   <= mag2;
                            opnd_q <= mag1;
                        end
                        if (op_is_div(md.op_i) && (md.opdata2_i == '0)) begin
                            state <= MD_DZERO;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (!md.start_i) begin
                        state <= MD_IDLE;
                    end else begin
                        hi_q <= step_hi;
                        lo_q <= step_lo;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= MD_FIXUP;
                        end
                    end
                end
                MD_FIXUP: begin
                    if (!md.start_i) begin
                        state <= MD_IDLE;
                    end else begin
                        result_q <= fixed;
                        ready_q  <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
                MD_DZERO: begin
                    if (!md.start_i) begin
                        state <= MD_IDLE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!md.stall_i) begin
                        ready_q <= 1'b0;
                        state   <= MD_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= MD_IDLE;
                end
            endcase
        end
    end

    assign md.stallreq_o = md.start_i & ~ready_q;
    assign md.ready_o    = ready_q;
    assign md.result_o   = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases plus random ops against an arithmetic model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        int          due;
        int          len;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         acc_off = 1;
    sb_item_t   sb[$];
    sb_item_t   cur;
    bit         have_cur = 0;
    bit         prev_rdy = 0;
    int         run_len = 0;

    ex_muldiv_if #(.DATA_W(32)) md ();

    ex_muldiv #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(md_op_t op, logic [31:0] a, logic [31:0] b,
                                          logic [63:0] acc);
        longint      sa;
        longint      sb_v;
        logic [63:0] sp;
        logic [63:0] up;
        logic [63:0] q;
        logic [63:0] r;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        sp   = sa * sb_v;
        up   = {32'b0, a} * {32'b0, b};
        case (op)
            MD_MULT:  return sp;
            MD_MULTU: return up;
            MD_DIV: begin
                if (b == 0) return 64'd0;
                q = sa / sb_v;
                r = sa % sb_v;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            MD_MADD:  return acc + sp;
            MD_MADDU: return acc + up;
            MD_MSUB:  return acc - sp;
            MD_MSUBU: return acc - up;
            default:  return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: sampled 1 time unit after the falling edge so driver updates have settled.
    always @(negedge clk) begin
        #1;
        chk("stallreq", 64'(md.stallreq_o), 64'(md.start_i & ~md.ready_o));
        if (md.ready_o && !prev_rdy) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
                cur      = sb.pop_front();
                have_cur = 1;
                run_len  = 1;
                chk("result", md.result_o, cur.res);
                chk("latency", 64'(cyc), 64'(cur.due));
            end
        end else if (md.ready_o) begin
            run_len++;
            if (have_cur) chk("result_hold", md.result_o, cur.res);
        end else if (prev_rdy && have_cur) begin
            chk("ready_len", 64'(run_len), 64'(cur.len));
            have_cur = 0;
        end
        prev_rdy = md.ready_o;
    end

    // Called at a falling edge; acc_off says how many rising edges until the op is accepted.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] acc, input logic [63:0] exp,
                          input int stall_cyc, input bit next_b2b);
        sb_item_t it;
        int       n;
        bit       dz;
        dz = (op == MD_DIV || op == MD_DIVU) && (b == 0);
        md.start_i   = 1'b1;
        md.op_i      = op;
        md.opdata1_i = a;
        md.opdata2_i = b;
        md.acc_hi_i  = acc[63:32];
        md.acc_lo_i  = acc[31:0];
        it.res = exp;
        it.due = cyc + (acc_off - 1) + (dz ? 2 : 34);
        it.len = stall_cyc;
        sb.push_back(it);
        for (int k = 0; k < acc_off; k++) begin
            @(negedge clk);
            md.annul_i = 1'b0;
        end
        // Accepted now: later operand changes must not matter.
        md.opdata1_i = $urandom;
        md.opdata2_i = $urandom;
        md.acc_hi_i  = $urandom;
        md.acc_lo_i  = $urandom;
        md.stall_i   = (stall_cyc > 1);
        n = 0;
        while (!md.ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!md.ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready_o within 60 cycles, expected ready (cycle %0d)", cyc);
            md.start_i = 1'b0;
            md.stall_i = 1'b0;
            @(negedge clk);
            acc_off = 1;
            return;
        end
        for (int k = 1; k < stall_cyc; k++) @(negedge clk);
        md.stall_i = 1'b0;
        if (next_b2b) begin
            acc_off = 2;
        end else begin
            md.start_i = 1'b0;
            @(negedge clk);
            acc_off = 1;
        end
    endtask

    md_op_t      r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;

    initial begin
        rst          = 1'b1;
        md.start_i   = 1'b0;
        md.op_i      = MD_MULT;
        md.opdata1_i = '0;
        md.opdata2_i = '0;
        md.acc_hi_i  = '0;
        md.acc_lo_i  = '0;
        md.annul_i   = 1'b0;
        md.stall_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(md.ready_o), 64'd0);
        chk("reset_result", md.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MD_DIVU, 32'd100, 32'd7, 64'd0, {32'h2, 32'hE}, 1, 0);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, 0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, {32'h0, 32'h8000_0000}, 1, 1);
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 1);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd5, 64'd0, 64'h0000_0004_FFFF_FFFB, 1, 0);
        run_op(MD_MADD, 32'd3, 32'hFFFF_FFFE, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFA, 1, 0);
        run_op(MD_MSUBU, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op(MD_DIVU, 32'd1234, 32'd0, 64'd0, 64'd0, 1, 0);
        run_op(MD_MULTU, 32'h0000_1234, 32'h10, 64'd0, 64'h0000_0000_0001_2340, 5, 0);
        run_op(MD_DIV, 32'h0000_0055, 32'd0, 64'd0, 64'd0, 3, 0);

        // Annul in the middle of CALC, with the counter at 10.
        md.start_i   = 1'b1;
        md.op_i      = MD_DIVU;
        md.opdata1_i = 32'hDEAD_BEEF;
        md.opdata2_i = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        md.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_ready", 64'(md.ready_o), 64'd0);
        md.annul_i = 1'b0;
        md.start_i = 1'b0;
        repeat (3) @(negedge clk);

        // annul_i alongside start_i in IDLE blocks acceptance for that cycle.
        md.annul_i = 1'b1;
        acc_off    = 2;
        run_op(MD_DIVU, 32'h8000_0000, 32'd1, 64'd0, {32'h0, 32'h8000_0000}, 1, 0);

        // start_i dropped mid-CALC: silent abort.
        md.start_i   = 1'b1;
        md.op_i      = MD_MULT;
        md.opdata1_i = 32'd7;
        md.opdata2_i = 32'd9;
        repeat (5) @(negedge clk);
        md.start_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_ready", 64'(md.ready_o), 64'd0);

        // Reset mid-CALC clears the outputs, including the held result.
        md.start_i   = 1'b1;
        md.op_i      = MD_MULTU;
        md.opdata1_i = 32'd11;
        md.opdata2_i = 32'd13;
        repeat (6) @(negedge clk);
        rst        = 1'b1;
        md.start_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(md.ready_o), 64'd0);
        chk("midrst_result", md.result_o, 64'd0);
        chk("midrst_stallreq", 64'(md.stallreq_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            r_op  = md_op_t'($urandom_range(0, 7));
            r_a   = pick();
            r_b   = pick();
            r_acc = {pick(), pick()};
            run_op(r_op, r_a, r_b, r_acc, model(r_op, r_a, r_b, r_acc),
                   $urandom_range(1, 3), (i < 39) && ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("no_open_response", 64'(have_cur), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
